mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the fetch stage (IF, read-only) and the memory stage (MEM, load/store).
- Sequences one outstanding memory transaction at a time with a req/gnt/rvalid handshake.
- Raises a stall request toward the pipeline hazard control while either stage waits.
- Discards in-flight fetch responses after a branch-mispredict flush.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive fetch losses before fetch gets forced priority (only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- iReqF  in  1  fetch read request; held until iValidF
- iAddrF  in  ADDR_W  fetch address
- iDataF  out  DATA_W  fetch read data; valid only while iValidF=1
- iValidF  out  1  fetch response, one-cycle pulse
- flushF  in  1  fetch redirect (mispredict); cancels current fetch
- dReqM  in  1  data request; held with stable fields until dValidM
- dWeM  in  1  1 = store, 0 = load
- dAddrM  in  ADDR_W  data address
- dWdataM  in  DATA_W  store data
- dBeM  in  DATA_W/8  byte enables
- dRdataM  out  DATA_W  load data; valid only while dValidM=1
- dValidM  out  1  data response, one-cycle pulse (loads and stores)
- memReq  out  1  memory request
- memWe  out  1  memory write enable
- memAddr  out  ADDR_W  memory address
- memWdata  out  DATA_W  memory write data
- memBe  out  DATA_W/8  memory byte enables
- memGnt  in  1  request accepted this cycle
- memRvalid  in  1  transaction complete (read data or write ack)
- memRdata  in  DATA_W  memory read data
- stallReq  out  1  to hazard control: a requester is waiting

Behaviour:
- States: IDLE, REQ_D, REQ_I, WAIT_D, WAIT_I. Reset → IDLE, drop=0, all outputs 0.

IDLE:
- If dReqM: latch data fields and go to REQ_D (data has priority).
- Else if iReqF and !flushF: latch iAddrF and go to REQ_I.
- iReqF is ignored in any cycle where flushF=1.

REQ_x:
- memReq=1; memWe/memAddr/memWdata/memBe are driven from registers and stay stable.
- memGnt=1 → WAIT_x. Without memGnt, remain in REQ_x indefinitely.
- For fetch, memWe=0 and memBe is all ones.

WAIT_x:
- memReq=0. Stay until memRvalid=1, then go to IDLE.
- dValidM = memRvalid & WAIT_D.
- iValidF = memRvalid & WAIT_I & !drop.
- dRdataM and iDataF are combinational pass-throughs of memRdata.

Latency (memGnt and memRvalid both zero-wait):
- Request seen cycle 0, memReq cycle 1, valid cycle 2, IDLE cycle 3.
- Back-to-back transactions have a minimum period of 3 cycles.

Flush:
- flushF in REQ_I or WAIT_I sets drop. The bus transaction still completes; the response is suppressed.
- drop clears on entry to IDLE.
- flushF in any other state has no effect.

stallReq:
- (iReqF & !iValidF) | (dReqM & !dValidM), gated to 0 in reset.
- Deasserts in the same cycle as the response pulse.

Simultaneous events:
- dReqM and iReqF in IDLE: data wins; fetch is served in the next IDLE.
- memRvalid in a REQ state is a protocol error and is ignored.
- memGnt outside REQ states is ignored.

Reset mid-transaction:
- Immediate return to IDLE; the outstanding transaction is abandoned.
- The memory side is reset in the same cycle.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A saturating counter counts IDLE arbitrations in which iReqF lost to dReqM.
  - When the count reaches STARVE_LIMIT, the next IDLE arbitration with both requests present grants fetch.
  - The counter clears on any fetch grant and on reset.
- Undefined: fixed data-over-fetch priority; no counter exists.

Test Plan:
- Zero-wait load: dReqM=1, dWeM=0, dAddrM=0x100, memGnt=1, memRvalid+memRdata=0xDEADBEEF one cycle after grant → memReq/memAddr=0x100 in cycle 1; dValidM=1 and dRdataM=0xDEADBEEF in cycle 2; stallReq=1 in cycles 0–1.
- Store with 3-cycle grant wait: dWeM=1, dAddrM=0x200, dWdataM=0x12345678, dBeM=0x3 → memReq and all mem fields stable for 3 cycles; dValidM pulses exactly once on memRvalid.
- Conflict: iReqF (0x0040) and dReqM (0x0300) together in IDLE → data transaction first, fetch immediately after; iValidF only after dValidM; stallReq stays high throughout.
- Flush in WAIT_I: fetch 0x0080 granted, flushF pulsed, memRvalid next cycle → iValidF stays 0; next fetch request 0x00C0 is issued from IDLE and returns normally.
- Reset in WAIT_D: reset=1 for one cycle → next cycle IDLE with all outputs 0; a late memRvalid produces no dValidM.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=2: iReqF held high, dReqM re-asserted at every IDLE → fetch is granted on the third contested arbitration.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store, one transaction at a time.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iReqF,
  input  logic [ADDR_W-1:0]     iAddrF,
  output logic [DATA_W-1:0]     iDataF,
  output logic                  iValidF,
  input  logic                  flushF,
  input  logic                  dReqM,
  input  logic                  dWeM,
  input  logic [ADDR_W-1:0]     dAddrM,
  input  logic [DATA_W-1:0]     dWdataM,
  input  logic [DATA_W/8-1:0]   dBeM,
  output logic [DATA_W-1:0]     dRdataM,
  output logic                  dValidM,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memWdata,
  output logic [DATA_W/8-1:0]   memBe,
  input  logic                  memGnt,
  input  logic                  memRvalid,
  input  logic [DATA_W-1:0]     memRdata,
  output logic                  stallReq
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, REQ_D, REQ_I, WAIT_D, WAIT_I} state_e;

  state_e              state_q;
  logic                drop_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic                take_d;
  logic                take_i;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q;
  logic             force_i;

  // Once fetch has lost STARVE_LIMIT contested arbitrations it wins the next one.
  assign force_i = (starve_q >= CNT_W'(STARVE_LIMIT));
  assign take_d  = dReqM & ~(force_i & iReqF & ~flushF);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (take_i) begin
        starve_q <= '0;
      end else if (take_d && iReqF && !flushF && !force_i) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  localparam int starve_limit_unused = STARVE_LIMIT;
  assign take_d = dReqM;
`endif

  assign take_i = iReqF & ~flushF & ~take_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (take_d) begin
            we_q    <= dWeM;
            addr_q  <= dAddrM;
            wdata_q <= dWdataM;
            be_q    <= dBeM;
            state_q <= REQ_D;
          end else if (take_i) begin
            we_q    <= 1'b0;
            addr_q  <= iAddrF;
            wdata_q <= '0;
            be_q    <= '1;
            state_q <= REQ_I;
          end
        end
        REQ_D: begin
          if (memGnt) state_q <= WAIT_D;
        end
        REQ_I: begin
          if (flushF) drop_q <= 1'b1;
          if (memGnt) state_q <= WAIT_I;
        end
        WAIT_D: begin
          if (memRvalid) state_q <= IDLE;
        end
        WAIT_I: begin
          // A flushed fetch still completes on the bus; only its response is hidden.
          if (memRvalid) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
          end else if (flushF) begin
            drop_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memReq   = (state_q == REQ_D) || (state_q == REQ_I);
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWdata = wdata_q;
  assign memBe    = be_q;

  assign dValidM  = ~reset & memRvalid & (state_q == WAIT_D);
  assign iValidF  = ~reset & memRvalid & (state_q == WAIT_I) & ~drop_q;
  assign dRdataM  = memRdata;
  assign iDataF   = memRdata;

  assign stallReq = ~reset & ((iReqF & ~iValidF) | (dReqM & ~dValidM));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single transactions plus
// hand-written conflict, flush and reset sequences; responses checked via a scoreboard queue.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iReqF;
  logic [31:0] iAddrF;
  logic [31:0] iDataF;
  logic        iValidF;
  logic        flushF;
  logic        dReqM;
  logic        dWeM;
  logic [31:0] dAddrM;
  logic [31:0] dWdataM;
  logic [3:0]  dBeM;
  logic [31:0] dRdataM;
  logic        dValidM;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memBe;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        stallReq;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .iReqF(iReqF), .iAddrF(iAddrF), .iDataF(iDataF), .iValidF(iValidF), .flushF(flushF),
    .dReqM(dReqM), .dWeM(dWeM), .dAddrM(dAddrM), .dWdataM(dWdataM), .dBeM(dBeM),
    .dRdataM(dRdataM), .dValidM(dValidM),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
    .memGnt(memGnt), .memRvalid(memRvalid), .memRdata(memRdata), .stallReq(stallReq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gnt_wait;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Response monitor: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (dValidM || iValidF) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got dValidM=%b iValidF=%b expected none", dValidM, iValidF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("resp_is_data", {31'd0, dValidM}, {31'd0, e.is_d});
        chk("resp_single", {31'd0, dValidM & iValidF}, 32'd0);
        chk("resp_data", dValidM ? dRdataM : iDataF, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iReqF = 0; iAddrF = '0; flushF = 0;
    dReqM = 0; dWeM = 0; dAddrM = '0; dWdataM = '0; dBeM = '0;
    memGnt = 0; memRvalid = 0; memRdata = '0;
  endtask

  // One full transaction from IDLE: request cycle, REQ cycles until grant, response cycle.
  task automatic do_txn(input vec_t v);
    exp_t e;
    if (v.is_d) begin
      dReqM = 1; dWeM = v.we; dAddrM = v.addr; dWdataM = v.wdata; dBeM = v.be;
    end else begin
      iReqF = 1; iAddrF = v.addr;
    end
    e.is_d = v.is_d; e.data = v.rdata;
    sb_q.push_back(e);
    @(negedge clk);
    chk("c0_stall", {31'd0, stallReq}, 32'd1);
    chk("c0_memReq", {31'd0, memReq}, 32'd0);
    step();
    for (int w = 0; w <= v.gnt_wait; w++) begin
      memGnt = (w == v.gnt_wait);
      @(negedge clk);
      chk("req_memReq", {31'd0, memReq}, 32'd1);
      chk("req_memAddr", memAddr, v.addr);
      chk("req_memWe", {31'd0, memWe}, {31'd0, v.is_d & v.we});
      chk("req_memBe", {28'd0, memBe}, {28'd0, v.is_d ? v.be : 4'hF});
      if (v.is_d && v.we) chk("req_memWdata", memWdata, v.wdata);
      chk("req_stall", {31'd0, stallReq}, 32'd1);
      step();
    end
    memGnt = 0; memRvalid = 1; memRdata = v.rdata;
    @(negedge clk);
    chk("wait_memReq", {31'd0, memReq}, 32'd0);
    chk("resp_stall", {31'd0, stallReq}, 32'd0);
    step();
    idle_inputs();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 0, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 3, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 1, 32'h0000_0013};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         4'hC, 0, 32'hA5A5_5A5A};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 2, 32'hFFFF_FFFF};

    idle_inputs();
    reset = 1;
    dReqM = 1;
    @(negedge clk);
    chk("rst_stall_gated", {31'd0, stallReq}, 32'd0);
    step();
    dReqM = 0;
    reset = 0;
    @(negedge clk);
    chk("rst_memReq", {31'd0, memReq}, 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memBe", {28'd0, memBe}, 32'd0);
    chk("rst_valids", {30'd0, dValidM, iValidF}, 32'd0);
    step();

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Fetch request during a flush is ignored in IDLE.
    iReqF = 1; iAddrF = 32'h0000_0040; flushF = 1;
    step();
    iReqF = 0; flushF = 0;
    @(negedge clk);
    chk("flush_idle_noreq", {31'd0, memReq}, 32'd0);
    step();

    // Conflict: data first, fetch right after.
    begin
      exp_t e;
      iReqF = 1; iAddrF = 32'h0000_0040;
      dReqM = 1; dWeM = 0; dAddrM = 32'h0000_0300; dBeM = 4'hF;
      e.is_d = 1; e.data = 32'hCAFE_0300; sb_q.push_back(e);
      e.is_d = 0; e.data = 32'h0BAD_0040; sb_q.push_back(e);
      step();
      memGnt = 1;
      @(negedge clk);
      chk("cf_d_addr", memAddr, 32'h0000_0300);
      chk("cf_d_stall", {31'd0, stallReq}, 32'd1);
      step();
      memGnt = 0; memRvalid = 1; memRdata = 32'hCAFE_0300;
      @(negedge clk);
      chk("cf_dvalid_stall", {31'd0, stallReq}, 32'd1);
      step();
      dReqM = 0; memRvalid = 0;
      @(negedge clk);
      chk("cf_idle_stall", {31'd0, stallReq}, 32'd1);
      step();
      memGnt = 1;
      @(negedge clk);
      chk("cf_i_addr", memAddr, 32'h0000_0040);
      chk("cf_i_we", {31'd0, memWe}, 32'd0);
      step();
      memGnt = 0; memRvalid = 1; memRdata = 32'h0BAD_0040;
      @(negedge clk);
      chk("cf_ivalid_stall", {31'd0, stallReq}, 32'd0);
      step();
      idle_inputs();
    end

    // Flush in WAIT_I: response suppressed, next fetch normal.
    iReqF = 1; iAddrF = 32'h0000_0080;
    step();
    memGnt = 1;
    step();
    memGnt = 0; flushF = 1;
    step();
    flushF = 0; memRvalid = 1; memRdata = 32'h1111_2222;
    @(negedge clk);
    chk("flush_ivalid", {31'd0, iValidF}, 32'd0);
    step();
    idle_inputs();
    do_txn('{1'b0, 1'b0, 32'h0000_00C0, 32'h0, 4'hF, 0, 32'h3333_4444});

    // Reset in WAIT_D abandons the transaction.
    dReqM = 1; dWeM = 1; dAddrM = 32'h0000_0500; dWdataM = 32'h5555_AAAA; dBeM = 4'hF;
    step();
    memGnt = 1;
    step();
    memGnt = 0; reset = 1;
    step();
    reset = 0; dReqM = 0; dWeM = 0; dAddrM = '0; dWdataM = '0; dBeM = '0;
    @(negedge clk);
    chk("rwd_memReq", {31'd0, memReq}, 32'd0);
    chk("rwd_memWe", {31'd0, memWe}, 32'd0);
    chk("rwd_memAddr", memAddr, 32'd0);
    chk("rwd_memWdata", memWdata, 32'd0);
    chk("rwd_stall", {31'd0, stallReq}, 32'd0);
    step();
    memRvalid = 1; memRdata = 32'h7777_7777;
    @(negedge clk);
    chk("rwd_late_dvalid", {31'd0, dValidM}, 32'd0);
    step();
    idle_inputs();
    step();

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
